// File: rtl/rate_hex_counter_pkg.sv
// ---------------------------------------------------------------------------
// rate_hex_counter_pkg
//   Shared definitions for the rate-controlled hex counter:
//     - speed_e     : encoding of the 2-bit Speed select
//     - period()    : cycles between ticks for a given speed and clock rate
//     - rd_width()  : width of the rate-divider down-counter
// ---------------------------------------------------------------------------
package rate_hex_counter_pkg;

  // Speed select encoding. The values are fixed by the board-level
  // switch wiring, so they are pinned explicitly.
  typedef enum logic [1:0] {
    SPD_FAST    = 2'b00,  // advance every enabled cycle
    SPD_1HZ     = 2'b01,  // once per second
    SPD_HALF    = 2'b10,  // once every two seconds
    SPD_QUARTER = 2'b11   // once every four seconds
  } speed_e;

  // Number of clock cycles between successive ticks.
  function automatic int unsigned period(input speed_e spd,
                                         input int unsigned clock_freq);
    int unsigned p;
    p = 1;
    case (spd)
      SPD_FAST:    p = 1;
      SPD_1HZ:     p = clock_freq;
      SPD_HALF:    p = 2 * clock_freq;
      SPD_QUARTER: p = 4 * clock_freq;
      default:     p = 1;
    endcase
    return p;
  endfunction

  // The divider must hold the longest reload value, 4*CLOCK_FREQ-1.
  // Clamped to at least one bit so a degenerate CLOCK_FREQ still elaborates.
  function automatic int unsigned rd_width(input int unsigned clock_freq);
    int unsigned w;
    w = $clog2(4 * clock_freq);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// ---------------------------------------------------------------------------
// rate_divider
//   Programmable down-counter that produces a one-cycle tick every
//   period(Speed) enabled cycles. Any reload (reset, load, or a change of the
//   speed select) restarts the period so the first tick after it comes a
//   full period later.
//
//   Ports
//     clk     : rising-edge clock
//     reset   : synchronous, active-high
//     enable  : run the divider; low freezes the remaining count
//     speed   : rate select (speed_e encoding)
//     load    : parallel load of the counter above; restarts the period
//     tick    : high in each cycle whose rising edge should advance the count
//
//   Parameters
//     CLOCK_FREQ : clock cycles per second
// ---------------------------------------------------------------------------
module rate_divider
  import rate_hex_counter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       load,
  output logic       tick
);

  localparam int unsigned RD_W = rd_width(CLOCK_FREQ);

  logic [RD_W-1:0] rd;            // cycles remaining before the next tick
  logic [1:0]      speed_q;       // speed select seen on the previous edge
  logic            speed_changed;
  logic [RD_W-1:0] reload_val;    // period(speed) - 1 for the live select

  assign speed_changed = (speed != speed_q);
  assign reload_val    = RD_W'(period(speed_e'(speed), CLOCK_FREQ) - 1);

  // Tick is decoded combinationally so it lines up with the edge that
  // advances the counter. Every higher-priority event masks it.
  assign tick = enable & ~reset & ~load & ~speed_changed & (rd == '0);

  // Priority: reset > load > speed change > normal countdown.
  // A speed change restarts the period even while disabled, so the new rate
  // always takes effect from a clean boundary.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    speed_q <= speed;
    if (reset) begin
      rd <= reload_val;
    end else if (load) begin
      rd <= reload_val;
    end else if (speed_changed) begin
      rd <= reload_val;
    end else if (enable) begin
      if (rd == '0) begin
        rd <= reload_val;
      end else begin
        rd <= rd - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rate_hex_counter.sv
// ---------------------------------------------------------------------------
// rate_hex_counter
//   Single hex digit that counts up or down at a selectable rate, with a
//   synchronous parallel load. Q feeds the 7-segment decoder at board top.
//
//   Ports
//     Clock   : rising-edge system clock
//     Reset   : synchronous, active-high; Q -> 0, divider restarts
//     Enable  : high lets the rate divider run; low freezes divider and Q
//     Speed   : rate select (00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz)
//     Load    : load D into Q on the next edge, regardless of Enable
//     D       : load value
//     Up      : 1 counts up, 0 counts down (both wrap modulo 16)
//     Q       : current hex digit
//     Tick    : high in exactly the cycles whose rising edge advances Q
//
//   Parameters
//     CLOCK_FREQ : clock cycles per second
// ---------------------------------------------------------------------------
module rate_hex_counter
  import rate_hex_counter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [1:0] Speed,
  input  logic       Load,
  input  logic [3:0] D,
  input  logic       Up,
  output logic [3:0] Q,
  output logic       Tick
);

  logic [3:0] q_next;

  rate_divider #(
    .CLOCK_FREQ(CLOCK_FREQ)
  ) u_rate_divider (
    .clk    (Clock),
    .reset  (Reset),
    .enable (Enable),
    .speed  (Speed),
    .load   (Load),
    .tick   (Tick)
  );

  // 4-bit arithmetic wraps naturally: F+1 -> 0 and 0-1 -> F.
  // NOTE: q_next is assigned on every path through the block, so no latch
  // can be inferred.
  always_comb begin
    q_next = Q;
    if (Tick) begin
      q_next = Up ? (Q + 4'd1) : (Q - 4'd1);
    end
  end

  // Reset beats load, load beats a tick. Tick already carries the Enable
  // gating, so a disabled counter holds without extra logic here.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= 4'h0;
    end else if (Load) begin
      Q <= D;
    end else begin
      Q <= q_next;
    end
  end

endmodule

// File: tb/tb_rate_hex_counter.sv
// ---------------------------------------------------------------------------
// tb_rate_hex_counter
//   Self-checking bench for rate_hex_counter with CLOCK_FREQ = 4, giving
//   periods of 1/4/8/16 cycles. Directed vectors from a table, hand-written
//   multi-cycle sequences, and randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_rate_hex_counter;

  localparam int unsigned CF = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic [1:0] Speed = 2'b00;
  logic       Load = 1'b0;
  logic [3:0] D = 4'h0;
  logic       Up = 1'b1;
  logic [3:0] Q;
  logic       Tick;

  rate_hex_counter #(
    .CLOCK_FREQ(CF)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .Speed  (Speed),
    .Load   (Load),
    .D      (D),
    .Up     (Up),
    .Q      (Q),
    .Tick   (Tick)
  );

  always #5 Clock = ~Clock;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the digit as an integer, the number of enabled cycles
  // still to wait (1 means "ticks this cycle"), and the previous speed.
  int   m_q    = 0;
  int   m_left = 1;
  int   m_prev = 0;
  logic last_tick;

  function automatic int per(input int spd);
    case (spd)
      0:       return 1;
      1:       return CF;
      2:       return 2 * CF;
      default: return 4 * CF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check Tick before
  // the rising edge, advance the model, then check Q just after the edge.
  task automatic step(input logic rst, input logic en, input logic [1:0] spd,
                      input logic ld, input logic [3:0] d, input logic up);
    logic exp_t;
    @(negedge Clock);
    Reset = rst; Enable = en; Speed = spd; Load = ld; D = d; Up = up;
    #1;
    exp_t = !rst && !ld && en && (int'(spd) == m_prev) && (m_left == 1);
    last_tick = Tick;
    check("tick", {31'b0, Tick}, {31'b0, exp_t});
    @(posedge Clock);
    if (rst) begin
      m_q = 0; m_left = per(int'(spd));
    end else if (ld) begin
      m_q = int'(d); m_left = per(int'(spd));
    end else if (int'(spd) != m_prev) begin
      m_left = per(int'(spd));
    end else if (en) begin
      if (m_left == 1) begin
        m_left = per(int'(spd));
        m_q = up ? (m_q + 1) % 16 : (m_q + 15) % 16;
      end else begin
        m_left = m_left - 1;
      end
    end
    m_prev = int'(spd);
    #1;
    check("q", {28'b0, Q}, m_q);
  endtask

  // Run with fixed inputs until Tick is seen; n is the cycle count including
  // the ticking cycle, or -1 if no tick arrives within the budget.
  task automatic run_until_tick(input logic en, input logic [1:0] spd,
                                input logic up, output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, en, spd, 1'b0, 4'h0, up);
      n++;
      if (last_tick === 1'b1) found = 1;
    end
    if (!found) n = -1;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] spd;
    logic       ld;
    logic [3:0] d;
    logic       up;
    logic       exp_tick;
    logic [3:0] exp_q;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int n;
    int qhold;

    // rst en spd ld d up | tick q-after-edge
    tbl[0]  = '{1'b1, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    // Speed 01 from reset: tick in the 4th cycle, Q=1 then Q=2.
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b1, 4'h1};
    tbl[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h1};
    tbl[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h1};
    tbl[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h1};
    tbl[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b1, 4'h2};
    tbl[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h2};
    tbl[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h2};
    tbl[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'h2};
    // Load A exactly when the divider is at zero: no tick, no increment.
    tbl[12] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'hA, 1'b1, 1'b0, 4'hA};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'hA};
    tbl[14] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'hA};
    tbl[15] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 4'hA};
    tbl[16] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b1, 4'hB};
    // Reset together with load: reset wins.
    tbl[17] = '{1'b1, 1'b1, 2'b01, 1'b1, 4'h7, 1'b1, 1'b0, 4'h0};
    // Switch to speed 00 counting down: change cycle is silent, then F, E.
    tbl[18] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[19] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 4'hF};
    tbl[20] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 4'hE};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].spd, tbl[i].ld, tbl[i].d, tbl[i].up);
      check($sformatf("tbl%0d_tick", i), {31'b0, last_tick},
            {31'b0, tbl[i].exp_tick});
      check($sformatf("tbl%0d_q", i), {28'b0, Q}, {28'b0, tbl[i].exp_q});
    end

    // Speed 01 -> 11 mid-period: silent change cycle, next tick 16 later.
    step(1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 2'b11, 1'b0, 4'h0, 1'b0);
    check("spdchg_tick", {31'b0, last_tick}, 32'd0);
    run_until_tick(1'b1, 2'b11, 1'b0, n);
    check("spdchg_latency", n, 32'd16);

    // Fast mode wraps through all sixteen values.
    step(1'b1, 1'b1, 2'b00, 1'b0, 4'h0, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 1'b1);
      check($sformatf("fast_q%0d", i), {28'b0, Q}, i % 16);
      check($sformatf("fast_tick%0d", i), {31'b0, last_tick}, 32'd1);
    end

    // Two counted cycles, ten disabled cycles, then the tick resumes after 2.
    step(1'b1, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    qhold = int'(Q);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 2'b01, 1'b0, 4'h0, 1'b1);
      check("hold_q", {28'b0, Q}, qhold);
    end
    run_until_tick(1'b1, 2'b01, 1'b1, n);
    check("resume_latency", n, 32'd2);

    // Reset with load mid-period: Q=0, no tick, full period afterwards.
    step(1'b0, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b1, 2'b01, 1'b1, 4'h7, 1'b1);
    check("rstld_tick", {31'b0, last_tick}, 32'd0);
    check("rstld_q", {28'b0, Q}, 32'd0);
    run_until_tick(1'b1, 2'b01, 1'b1, n);
    check("rstld_latency", n, 32'd4);

    // Randomized traffic against the model.
    begin
      logic       r_rst, r_en, r_ld, r_up;
      logic [1:0] r_spd;
      logic [3:0] r_d;
      r_spd = 2'b01;
      for (int i = 0; i < 600; i++) begin
        r_rst = ($urandom_range(0, 39) == 0);
        r_ld  = ($urandom_range(0, 9) == 0);
        r_en  = ($urandom_range(0, 3) != 0);
        r_up  = $urandom_range(0, 1) == 1;
        r_d   = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 19) == 0) r_spd = 2'($urandom_range(0, 3));
        step(r_rst, r_en, r_spd, r_ld, r_d, r_up);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rate_hex_counter.md
RATE_HEX_COUNTER -- requirements
Module: rate_hex_counter

Interface
REQ-001 The block SHALL declare parameter CLOCK_FREQ, default 50_000_000, meaning Clock cycles per second (reduced to 4 in simulation).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port Clock, input, 1 bit: rising-edge system clock.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port Enable, input, 1 bit: high lets the rate divider run; low freezes the divider and Q.
REQ-006 Port Speed, input, 2 bits: rate select (00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz).
REQ-007 Port Load, input, 1 bit: synchronous parallel load of D into Q.
REQ-008 Port D, input, 4 bits: load value.
REQ-009 Port Up, input, 1 bit: 1 counts up, 0 counts down.
REQ-010 Port Q, output, 4 bits: current hex digit, driving the existing 7-segment decoder at board top.
REQ-011 Port Tick, output, 1 bit: high in exactly the cycles whose rising edge advances Q.

Function
REQ-012 Period P(Speed) SHALL be 1, CLOCK_FREQ, 2*CLOCK_FREQ, 4*CLOCK_FREQ cycles for Speed 00/01/10/11.
REQ-013 Divider register RD SHALL be an unsigned down-counter sized ceil(log2(4*CLOCK_FREQ)) bits (28 at default).
REQ-014 Tick SHALL equal Enable & ~Reset & ~Load & ~SpeedChanged & (RD==0), decoded combinationally from registers and inputs.
REQ-015 When RD==0 and Enable=1, RD SHALL reload P(Speed)-1 on the next edge; otherwise, when Enable=1, RD SHALL decrement by 1.
REQ-016 With Enable=0, RD and Q SHALL hold; the remaining count SHALL resume when Enable returns high.
REQ-017 Speed SHALL be registered (SpeedQ); SpeedChanged = (Speed != SpeedQ).
REQ-018 When SpeedChanged, RD SHALL reload P(Speed)-1 and no tick SHALL occur in that cycle.
REQ-019 On Tick with Up=1, Q SHALL become Q+1 mod 16 (F wraps to 0).
REQ-020 On Tick with Up=0, Q SHALL become Q-1 mod 16 (0 wraps to F).
REQ-021 Load=1 SHALL set Q to D and RD to P(Speed)-1 on the next edge, regardless of Enable.
REQ-022 Priority per edge SHALL be Reset > Load > SpeedChanged > Tick.
REQ-023 Speed=00 SHALL give P-1=0, so Tick is high every enabled cycle.
REQ-024 Latency from Load to Q SHALL be one edge.
REQ-025 The first Tick after a reload SHALL occur P cycles later.

Reset
REQ-026 On Reset, Q SHALL be 0, RD SHALL be P(Speed)-1, and SpeedQ SHALL be Speed.
REQ-027 Tick SHALL be 0 during any cycle with Reset=1.
REQ-028 Reset asserted mid-period or concurrently with Load SHALL override both.
REQ-029 Q SHALL read 0 on the edge after Reset.

Structure
REQ-030 A shared package SHALL hold the Speed encoding constants (SPD_FAST, SPD_1HZ, SPD_HALF, SPD_QUARTER) and the period function P.
REQ-031 The rate divider (RD, SpeedQ, reload logic) SHALL be one sub-module, rate_divider, outputting Tick.
REQ-032 The 4-bit up/down/load register SHALL reside in rate_hex_counter.

Verification (CLOCK_FREQ=4, so periods are 1/4/8/16)
REQ-033 Reset, Speed=00, Enable=1, Up=1 -> Q steps 0,1,…,F,0 on consecutive edges; Tick high every cycle.
REQ-034 Reset release, Speed=01 -> first Tick in the 4th cycle; Q=1 after 4 edges, Q=2 after 8.
REQ-035 Speed=00, Q=0, Up=0 -> Q goes F then E; Speed 01→11 mid-period -> no Tick that cycle, next Tick 16 cycles later.
REQ-036 Load=1, D=A coincident with RD==0 -> Q=A, no increment, next Tick 4 cycles later (Speed=01).
REQ-037 Speed=01, Enable low for 10 cycles after 2 counted cycles -> Q and RD hold; Tick comes 2 cycles after Enable returns.
REQ-038 Reset=1 with Load=1, D=7 mid-period -> Q=0, Tick=0, RD=P-1.
